uart_transmitter: RTL and testbench

//   8N1 UART serializer. Accepts a byte through a start/txe handshake, then

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_baud_tick.sv | 21 ++
 rtl/uart_transmitter.sv | 74 +++++++
 tb/tb_uart_transmitter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and line-level constants
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int   DATA_BITS   = 8;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic IDLE_LEVEL  = 1'b1;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer.
//   clk     in  clock
//   nrst    in  synchronous active-low reset
//   i_clear in  hold the count at zero (used while idle)
//   o_tick  out high on the last cycle of each bit period
module uart_baud_tick #(
    parameter int CLOCK_DIVIDER = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_clear,
    output logic o_tick
);
    localparam int W = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    logic [W-1:0] r_cnt;
    assign o_tick = r_cnt == W'(CLOCK_DIVIDER - 1);
    always_ff @(posedge clk) begin
        if (!nrst || i_clear || o_tick) r_cnt <= '0;
        else                            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serializer with start/txe handshake.
//   clk     in  clock
//   nrst    in  synchronous active-low reset
//   start   in  send request, accepted only while txe=1
//   data_in in  byte to send, sampled on the accept edge
//   tx      out registered serial line, idles high
//   txe     out registered ready flag, high only when idle
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_DIVIDER = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       txe
);
    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit;
    logic       w_tick;
    logic       w_clear;
    // Holding the timer clear while idle makes the first start-bit cycle count zero.
    assign w_clear = r_state == IDLE;
    uart_baud_tick #(.CLOCK_DIVIDER(CLOCK_DIVIDER)) u_baud (
        .clk    (clk),
        .nrst   (nrst),
        .i_clear(w_clear),
        .o_tick (w_tick)
    );
    // The shift register is pre-shifted so tx always loads from bit 0.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= IDLE;
            tx      <= IDLE_LEVEL;
            txe     <= 1'b1;
            r_shift <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_shift <= data_in;
                    tx      <= START_LEVEL;
                    txe     <= 1'b0;
                    r_state <= START;
                end
                START: if (w_tick) begin
                    tx      <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_bit   <= '0;
                    r_state <= DATA;
                end
                DATA: if (w_tick) begin
                    if (r_bit == 3'(DATA_BITS - 1)) begin
                        tx      <= STOP_LEVEL;
                        r_state <= STOP;
                    end else begin
                        tx      <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 3'd1;
                    end
                end
                STOP: if (w_tick) begin
                    tx      <= IDLE_LEVEL;
                    txe     <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench over three divider settings (2, 1, 5)
module tb_uart_transmitter;
    logic       clk = 1'b0;
    logic [2:0] nrst;
    logic [2:0] start;
    logic [7:0] data_in [3];
    logic [2:0] tx;
    logic [2:0] txe;
    logic [7:0] exp_q [3][$];
    logic [7:0] bq [$];
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    function automatic int dval(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 5;
    endfunction

    // Expected line waveform, one entry per clock: start, 8 data bits LSB first, stop.
    function automatic logic [63:0] model(input logic [7:0] b, input int d);
        logic [9:0]  fr;
        logic [63:0] m;
        fr = {1'b1, b, 1'b0};
        m  = '0;
        for (int k = 0; k < 10 * d; k++) m[k] = fr[k / d];
        return m;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : 5;
        uart_transmitter #(.CLOCK_DIVIDER(D)) dut (
            .clk    (clk),
            .nrst   (nrst[g]),
            .start  (start[g]),
            .data_in(data_in[g]),
            .tx     (tx[g]),
            .txe    (txe[g])
        );
        initial begin : mon
            logic        prev;
            logic [63:0] wave;
            logic [7:0]  b;
            int          k;
            bit          ab;
            bit          low_ok;
            prev = 1'b0;
            forever begin
                @(negedge clk);
                if (prev === 1'b1 && txe[g] === 1'b0 && nrst[g] === 1'b1) begin
                    wave = '0; k = 0; ab = 0; low_ok = 1;
                    while (k < 10 * D && !ab) begin
                        if (nrst[g] !== 1'b1) ab = 1;
                        else begin
                            wave[k] = tx[g];
                            if (txe[g] !== 1'b0) low_ok = 0;
                            k++;
                            if (k < 10 * D) @(negedge clk);
                        end
                    end
                    if (!ab) begin
                        @(negedge clk);
                        chk($sformatf("txe_window_d%0d", D), low_ok && txe[g] === 1'b1, {63'd0, txe[g]}, 64'd1);
                        if (exp_q[g].size() == 0) chk($sformatf("unexpected_frame_d%0d", D), 1'b0, wave, 64'd0);
                        else begin
                            b = exp_q[g].pop_front();
                            chk($sformatf("frame_d%0d_%h", D, b), wave === model(b, D), wave, model(b, D));
                        end
                    end
                end
                prev = txe[g];
            end
        end
    end

    task automatic wait_txe(input int g, output int n);
        n = 0;
        while (txe[g] !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            data_in[g] = 8'($urandom);
            n++;
        end
        if (txe[g] !== 1'b1) chk("txe_timeout", 1'b0, {63'd0, txe[g]}, 64'd1);
    endtask

    task automatic send(input int g, input logic [7:0] b);
        int n;
        wait_txe(g, n);
        data_in[g] = b;
        start[g] = 1'b1;
        @(posedge clk); #1;
        exp_q[g].push_back(b);
        start[g] = 1'b0;
        data_in[g] = 8'($urandom);
    endtask

    // start held high as if tied to txe; data_in scrambles while busy.
    task automatic stream(input int g, input logic [7:0] bs [$]);
        int n;
        start[g] = 1'b1;
        foreach (bs[i]) begin
            wait_txe(g, n);
            if (i > 0) chk($sformatf("busy_len_d%0d", dval(g)), n == 10 * dval(g), 64'(n), 64'(10 * dval(g)));
            data_in[g] = bs[i];
            @(posedge clk); #1;
            exp_q[g].push_back(bs[i]);
            data_in[g] = 8'($urandom);
        end
        start[g] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n;
        nrst = '0; start = '0;
        for (int i = 0; i < 3; i++) data_in[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_tx%0d", i), tx[i] === 1'b1, {63'd0, tx[i]}, 64'd1);
            chk($sformatf("reset_txe%0d", i), txe[i] === 1'b1, {63'd0, txe[i]}, 64'd1);
        end
        nrst = '1;
        ok = 1;
        repeat (50) begin
            @(posedge clk); #1;
            if (tx[0] !== 1'b1 || txe[0] !== 1'b1) ok = 0;
        end
        chk("idle_hold", ok, {63'd0, tx[0]}, 64'd1);
        send(0, 8'h48);
        bq = '{8'h48, 8'h65};
        stream(0, bq);
        // Abort a frame during data bit 3 (cycles 8..9 after the accept edge at D=2).
        send(0, 8'hC3);
        repeat (8) @(posedge clk);
        #1;
        nrst[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort_tx", tx[0] === 1'b1, {63'd0, tx[0]}, 64'd1);
        chk("abort_txe", txe[0] === 1'b1, {63'd0, txe[0]}, 64'd1);
        nrst[0] = 1'b1;
        void'(exp_q[0].pop_back());
        send(0, 8'h5A);
        send(1, 8'hA5);
        send(2, 8'hA5);
        for (int g = 0; g < 3; g++) begin
            bq = {};
            repeat (4) bq.push_back(8'($urandom));
            stream(g, bq);
            send(g, 8'($urandom));
        end
        for (int g = 0; g < 3; g++) wait_txe(g, n);
        repeat (3) @(posedge clk);
        #1;
        chk("drain", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() == 0,
            64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
